// File: rtl/tdm_pkg.sv
// Shared types for the 4:1 TDM demultiplexer: FSM state encoding and slot index.
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned SLOTS = 4;

    typedef logic [1:0] slot_t;

endpackage

// File: rtl/tdm_dmx4_if.sv
// Incoming TDM stream: one slot per valid beat, frame_sync marks slot 0.
interface tdm_dmx4_if #(
    parameter int unsigned W = 8
);
    logic [W-1:0] din;
    logic         din_valid;
    logic         frame_sync;

    modport master (output din, din_valid, frame_sync);
    modport slave  (input  din, din_valid, frame_sync);
endinterface

// File: rtl/tdm_dmx4_slot_ctr.sv
// 2-bit slot counter: wraps 3->0 on enable, loads 1 on a slot-0 capture, clears on lock loss.
module tdm_slot_ctr
    import tdm_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  clr,
    input  logic  load1,
    input  logic  en,
    output slot_t cnt
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= slot_t'(1);
        end else if (en) begin
            cnt <= cnt + slot_t'(1);
        end
    end

endmodule

// File: rtl/tdm_dmx4.sv
// 4:1 TDM demultiplexer: shadows slots 0..2, then commits all four channels on the slot-3 beat.
module tdm_dmx4
    import tdm_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned MAXERR = 3
) (
    input  logic             clk,
    input  logic             reset,
    tdm_dmx4_if.slave        link,
    output logic [W-1:0]     q0,
    output logic [W-1:0]     q1,
    output logic [W-1:0]     q2,
    output logic [W-1:0]     q3,
    output logic             frame_valid,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             sync_err
);

    localparam slot_t LAST_SLOT = slot_t'(SLOTS - 1);

    state_t       state, state_nxt;
    slot_t        slot_q;
    logic [2:0]   err_cnt, err_nxt, err_inc;
    logic [W-1:0] s0, s1, s2;
    logic         cap0, cap1, cap2, commit, serr_nxt;
    logic         slot_clr, slot_load1, slot_en;

    tdm_slot_ctr u_slot_ctr (
        .clk   (clk),
        .reset (reset),
        .clr   (slot_clr),
        .load1 (slot_load1),
        .en    (slot_en),
        .cnt   (slot_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        err_inc    = err_cnt + 3'd1;
        err_nxt    = err_cnt;
        cap0       = 1'b0;
        cap1       = 1'b0;
        cap2       = 1'b0;
        commit     = 1'b0;
        serr_nxt   = 1'b0;
        slot_clr   = 1'b0;
        slot_load1 = 1'b0;
        slot_en    = 1'b0;
        if (link.din_valid) begin
            case (state)
                HUNT: begin
                    if (link.frame_sync) begin
                        cap0       = 1'b1;
                        slot_load1 = 1'b1;
                        err_nxt    = '0;
                        state_nxt  = RUN;
                    end
                end
                RUN: begin
                    if (link.frame_sync && slot_q != '0) begin
                        serr_nxt = 1'b1;
                        // Lock loss drops the beat; otherwise the sync beat restarts the frame.
                        if (err_inc == 3'(MAXERR)) begin
                            state_nxt = HUNT;
                            slot_clr  = 1'b1;
                            err_nxt   = '0;
                        end else begin
                            err_nxt    = err_inc;
                            cap0       = 1'b1;
                            slot_load1 = 1'b1;
                        end
                    end else if (link.frame_sync) begin
                        cap0       = 1'b1;
                        slot_load1 = 1'b1;
                        err_nxt    = '0;
                    end else begin
                        slot_en = 1'b1;
                        cap0    = (slot_q == slot_t'(0));
                        cap1    = (slot_q == slot_t'(1));
                        cap2    = (slot_q == slot_t'(2));
                        commit  = (slot_q == LAST_SLOT);
                        if (slot_q == LAST_SLOT) begin
                            err_nxt = '0;
                        end
                    end
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt     <= '0;
            s0          <= '0;
            s1          <= '0;
            s2          <= '0;
            q0          <= '0;
            q1          <= '0;
            q2          <= '0;
            q3          <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            err_cnt     <= err_nxt;
            frame_valid <= commit;
            sync_err    <= serr_nxt;
            if (cap0) s0 <= link.din;
            if (cap1) s1 <= link.din;
            if (cap2) s2 <= link.din;
            if (commit) begin
                q0 <= s0;
                q1 <= s1;
                q2 <= s2;
                q3 <= link.din;
            end
        end
    end

    assign slot   = slot_q;
    assign locked = (state == RUN);

endmodule

// File: tb/tb_tdm_dmx4.sv
// Directed, table-driven bench for tdm_dmx4 with hand-computed expected outputs.
module tb_tdm_dmx4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] q0, q1, q2, q3;
    logic       frame_valid, locked, sync_err;
    logic [1:0] slot;

    int n_cmp = 0;
    int n_bad = 0;

    tdm_dmx4_if #(.W(8)) link ();

    tdm_dmx4 #(.W(8), .MAXERR(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .link        (link),
        .q0          (q0),
        .q1          (q1),
        .q2          (q2),
        .q3          (q3),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, v, s;
        logic [7:0]  d;
        logic [31:0] q;
        logic        fv;
        logic [1:0]  sl;
        logic        lk, se;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rst, v, s, input logic [7:0] d,
                                input logic [31:0] q, input logic fv,
                                input logic [1:0] sl, input logic lk, se);
        vec_t e;
        e.rst = rst; e.v = v; e.s = s; e.d = d;
        e.q = q; e.fv = fv; e.sl = sl; e.lk = lk; e.se = se;
        tbl.push_back(e);
    endfunction

    task automatic check(input string name, input logic [63:0] act, exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, v, s, input logic [7:0] d);
        reset           = rst;
        link.din_valid  = v;
        link.frame_sync = s;
        link.din        = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] qs();
        return 64'({q3, q2, q1, q0});
    endfunction

    function automatic logic [63:0] st();
        return 64'({frame_valid, sync_err, locked, slot});
    endfunction

    initial begin
        // 2: lock and first frame
        add(0,1,1,8'hA0, 32'h0,        0,2'd1,1,0);
        add(0,1,0,8'hA1, 32'h0,        0,2'd2,1,0);
        add(0,1,0,8'hA2, 32'h0,        0,2'd3,1,0);
        add(0,1,0,8'hA3, 32'hA3A2A1A0, 1,2'd0,1,0);
        add(0,0,0,8'h00, 32'hA3A2A1A0, 0,2'd0,1,0);
        // 3: gaps of two idle cycles between beats
        add(0,1,1,8'h10, 32'hA3A2A1A0, 0,2'd1,1,0);
        add(0,0,0,8'hEE, 32'hA3A2A1A0, 0,2'd1,1,0);
        add(0,0,1,8'hEE, 32'hA3A2A1A0, 0,2'd1,1,0);
        add(0,1,0,8'h11, 32'hA3A2A1A0, 0,2'd2,1,0);
        add(0,0,0,8'hEE, 32'hA3A2A1A0, 0,2'd2,1,0);
        add(0,0,0,8'hEE, 32'hA3A2A1A0, 0,2'd2,1,0);
        add(0,1,0,8'h12, 32'hA3A2A1A0, 0,2'd3,1,0);
        add(0,0,0,8'hEE, 32'hA3A2A1A0, 0,2'd3,1,0);
        add(0,0,0,8'hEE, 32'hA3A2A1A0, 0,2'd3,1,0);
        add(0,1,0,8'h13, 32'h13121110, 1,2'd0,1,0);
        add(0,0,0,8'h00, 32'h13121110, 0,2'd0,1,0);
        // 4: misaligned sync restarts the frame
        add(0,1,0,8'h01, 32'h13121110, 0,2'd1,1,0);
        add(0,1,0,8'h02, 32'h13121110, 0,2'd2,1,0);
        add(0,1,1,8'h55, 32'h13121110, 0,2'd1,1,1);
        add(0,1,0,8'h66, 32'h13121110, 0,2'd2,1,0);
        add(0,1,0,8'h77, 32'h13121110, 0,2'd3,1,0);
        add(0,1,0,8'h88, 32'h88776655, 1,2'd0,1,0);
        // 5: three consecutive sync errors lose lock
        add(0,1,1,8'h20, 32'h88776655, 0,2'd1,1,0);
        add(0,1,1,8'h21, 32'h88776655, 0,2'd1,1,1);
        add(0,1,1,8'h22, 32'h88776655, 0,2'd1,1,1);
        add(0,1,1,8'h23, 32'h88776655, 0,2'd0,0,1);
        add(0,1,0,8'h30, 32'h88776655, 0,2'd0,0,0);
        add(0,1,0,8'h31, 32'h88776655, 0,2'd0,0,0);
        add(0,1,1,8'h40, 32'h88776655, 0,2'd1,1,0);
        add(0,1,0,8'h41, 32'h88776655, 0,2'd2,1,0);
        // 6: reset mid-frame, then a clean frame
        add(1,1,0,8'h42, 32'h0,        0,2'd0,0,0);
        add(0,1,1,8'h50, 32'h0,        0,2'd1,1,0);
        add(0,1,0,8'h51, 32'h0,        0,2'd2,1,0);
        add(0,1,0,8'h52, 32'h0,        0,2'd3,1,0);
        add(0,1,0,8'h53, 32'h53525150, 1,2'd0,1,0);

        // 1: reset held two cycles with random stream activity
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'($urandom), 1'($urandom), 8'($urandom));
            check($sformatf("reset%0d_q", i), qs(), 64'h0);
            check($sformatf("reset%0d_status", i), st(), 64'h0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].s, tbl[i].d);
            check($sformatf("vec%0d_q", i), qs(), 64'(tbl[i].q));
            check($sformatf("vec%0d_status", i), st(),
                  64'({tbl[i].fv, tbl[i].se, tbl[i].lk, tbl[i].sl}));
        end

        // Back-to-back frames at full rate: pulse on every 4th beat only
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b1, (i % 4) == 0, 8'(8'h60 + i));
            check($sformatf("fullrate%0d_fv", i), 64'(frame_valid), 64'((i % 4) == 3));
            check($sformatf("fullrate%0d_serr", i), 64'(sync_err), 64'h0);
        end
        check("fullrate_q", qs(), 64'h6B6A6968);
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        check("fullrate_idle_status", st(), 64'({1'b0, 1'b0, 1'b1, 2'd0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
